// File: rtl/wb_sram_ctrl_pkg.sv
// Shared definitions for the Wishbone-to-async-SRAM controller.
// FSM encodings, phase timer width and parameter defaults.
package wb_sram_ctrl_pkg;

    localparam int unsigned TMR_W           = 4;
    localparam int unsigned DEF_SRAM_AW     = 18;
    localparam int unsigned DEF_WAIT_STATES = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_H0_SETUP = 3'd1,
        ST_H0_STRB  = 3'd2,
        ST_H1_SETUP = 3'd3,
        ST_H1_STRB  = 3'd4,
        ST_ACK      = 3'd5
    } state_e;

endpackage

// File: rtl/wb_sram_phase_timer.sv
// Loadable down-counter timing the strobe part of an SRAM/flash phase.
// Loaded during SETUP; done is high while the count sits at zero.
module wb_sram_phase_timer
    import wb_sram_ctrl_pkg::*;
#(
    parameter int unsigned W = TMR_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    // Count down to zero after each load, then hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone slave driving a 16-bit async SRAM in two halfword phases.
// Optional WB_SRAM_SKIP_UNSEL_EN skips halves with no byte selected.
module wb_sram_ctrl
    import wb_sram_ctrl_pkg::*;
#(
    parameter int unsigned SRAM_AW     = DEF_SRAM_AW,
    parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic               sys_clk,
    input  logic               resetcpu,
    input  logic               s_cyc,
    input  logic               s_stb,
    input  logic               s_we,
    input  logic [3:0]         s_sel,
    input  logic [31:0]        s_adr,
    input  logic [31:0]        s_dat_i,
    output logic [31:0]        s_dat_o,
    output logic               s_ack,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int unsigned HW = SRAM_AW - 1;
    localparam logic [TMR_W-1:0] WS_LD = TMR_W'(WAIT_STATES);

`ifdef WB_SRAM_SKIP_UNSEL_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    // A half runs unless skipping is enabled and both its selects are low.
    function automatic logic half_live(input logic [1:0] pair);
        return !SKIP_EN || (|pair);
    endfunction

    state_e            state_q, state_d;
    logic [HW-1:0]     adr_q, adr_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [31:0]       rdat_q, rdat_d;

    logic              ack_q, ack_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [15:0]       dqo_q, dqo_d;
    logic              dqoe_q, dqoe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              ub_n_q, ub_n_d;
    logic              lb_n_q, lb_n_d;

    logic              tmr_load;
    logic              tmr_done;
    logic              unused_adr;

    assign unused_adr = ^{s_adr[31:SRAM_AW+1], s_adr[1:0]};
    assign tmr_load   = (state_q == ST_H0_SETUP) || (state_q == ST_H1_SETUP);

    wb_sram_phase_timer #(
        .W          (TMR_W)
    ) u_timer (
        .clk_i      (sys_clk),
        .rst_ni     (resetcpu),
        .load_i     (tmr_load),
        .load_val_i (WS_LD),
        .done_o     (tmr_done)
    );

    // Next state, request latch and read-data capture.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (s_cyc && s_stb) begin
                    adr_d  = s_adr[SRAM_AW:2];
                    we_d   = s_we;
                    sel_d  = s_sel;
                    wdat_d = s_dat_i;
                    if (half_live(s_sel[3:2])) begin
                        state_d = ST_H0_SETUP;
                    end else if (half_live(s_sel[1:0])) begin
                        state_d = ST_H1_SETUP;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_H0_SETUP: state_d = ST_H0_STRB;
            ST_H0_STRB: begin
                if (tmr_done) begin
                    if (!we_q) begin
                        rdat_d[31:16] = sram_dq_i;
                    end
                    if (!s_cyc) begin
                        state_d = ST_IDLE;
                    end else if (half_live(sel_q[1:0])) begin
                        state_d = ST_H1_SETUP;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_H1_SETUP: state_d = ST_H1_STRB;
            ST_H1_STRB: begin
                if (tmr_done) begin
                    if (!we_q) begin
                        rdat_d[15:0] = sram_dq_i;
                    end
                    state_d = s_cyc ? ST_ACK : ST_IDLE;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin values for the state being entered, so every output is a flop.
    always_comb begin
        ack_d  = 1'b0;
        addr_d = addr_q;
        dqo_d  = dqo_q;
        dqoe_d = 1'b0;
        ce_n_d = 1'b1;
        oe_n_d = 1'b1;
        we_n_d = 1'b1;
        ub_n_d = 1'b1;
        lb_n_d = 1'b1;
        unique case (state_d)
            ST_H0_SETUP, ST_H0_STRB: begin
                ce_n_d = 1'b0;
                addr_d = {adr_d, 1'b0};
                dqo_d  = wdat_d[31:16];
                ub_n_d = ~sel_d[3];
                lb_n_d = ~sel_d[2];
                dqoe_d = we_d;
                if (state_d == ST_H0_STRB) begin
                    oe_n_d = we_d;
                    we_n_d = ~we_d;
                end
            end
            ST_H1_SETUP, ST_H1_STRB: begin
                ce_n_d = 1'b0;
                addr_d = {adr_d, 1'b1};
                dqo_d  = wdat_d[15:0];
                ub_n_d = ~sel_d[1];
                lb_n_d = ~sel_d[0];
                dqoe_d = we_d;
                if (state_d == ST_H1_STRB) begin
                    oe_n_d = we_d;
                    we_n_d = ~we_d;
                end
            end
            ST_ACK: begin
                ack_d  = 1'b1;
                dqoe_d = dqoe_q;
            end
            default: begin
                ack_d = 1'b0;
            end
        endcase
    end

    // FSM state and latched request.
    always_ff @(posedge sys_clk or negedge resetcpu) begin
        if (!resetcpu) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
        end
    end

    // Registered bus and pad outputs; reset parks the SRAM inactive.
    always_ff @(posedge sys_clk or negedge resetcpu) begin
        if (!resetcpu) begin
            ack_q  <= 1'b0;
            addr_q <= '0;
            dqo_q  <= '0;
            dqoe_q <= 1'b0;
            ce_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
            ub_n_q <= 1'b1;
            lb_n_q <= 1'b1;
        end else begin
            ack_q  <= ack_d;
            addr_q <= addr_d;
            dqo_q  <= dqo_d;
            dqoe_q <= dqoe_d;
            ce_n_q <= ce_n_d;
            oe_n_q <= oe_n_d;
            we_n_q <= we_n_d;
            ub_n_q <= ub_n_d;
            lb_n_q <= lb_n_d;
        end
    end

    assign s_ack      = ack_q;
    assign s_dat_o    = rdat_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dqo_q;
    assign sram_dq_oe = dqoe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_ub_n  = ub_n_q;
    assign sram_lb_n  = lb_n_q;

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Self-checking bench for wb_sram_ctrl against a byte-array reference.
// Second instance with WAIT_STATES=0 covers back-to-back reads.
module tb_wb_sram_ctrl;

    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        cyc = 0, stb = 0, we = 0;
    logic [3:0]  sel = 0;
    logic [31:0] adr = 0, dat_w = 0;
    logic [31:0] dat_r;
    logic        ack;
    logic [17:0] sram_addr;
    logic [15:0] dq_o, dq_i;
    logic        dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

    logic        cyc0 = 0, stb0 = 0;
    logic [31:0] adr0 = 0;
    logic [31:0] dat_r0;
    logic        ack0;
    logic [17:0] addr0;
    logic [15:0] dq_o0, dq_i0;
    logic        dq_oe0, ce_n0, oe_n0, we_n0, ub_n0, lb_n0;

    wb_sram_ctrl #(.SRAM_AW(18), .WAIT_STATES(WS)) dut (
        .sys_clk(clk), .resetcpu(rst_n), .s_cyc(cyc), .s_stb(stb),
        .s_we(we), .s_sel(sel), .s_adr(adr), .s_dat_i(dat_w),
        .s_dat_o(dat_r), .s_ack(ack), .sram_addr(sram_addr),
        .sram_dq_o(dq_o), .sram_dq_oe(dq_oe), .sram_dq_i(dq_i),
        .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
        .sram_ub_n(ub_n), .sram_lb_n(lb_n)
    );

    wb_sram_ctrl #(.SRAM_AW(18), .WAIT_STATES(0)) dut0 (
        .sys_clk(clk), .resetcpu(rst_n), .s_cyc(cyc0), .s_stb(stb0),
        .s_we(1'b0), .s_sel(4'hF), .s_adr(adr0), .s_dat_i(32'h0),
        .s_dat_o(dat_r0), .s_ack(ack0), .sram_addr(addr0),
        .sram_dq_o(dq_o0), .sram_dq_oe(dq_oe0), .sram_dq_i(dq_i0),
        .sram_ce_n(ce_n0), .sram_oe_n(oe_n0), .sram_we_n(we_n0),
        .sram_ub_n(ub_n0), .sram_lb_n(lb_n0)
    );

    function automatic logic [15:0] initpat(input int h);
        return 16'(h * 40503 + 4660);
    endfunction

    function automatic logic [15:0] pat0(input logic [17:0] a);
        return 16'((32'(a) * 32'd7919) ^ 32'h0000A5C3);
    endfunction

    // Async SRAM behaviour: read is combinational, write on strobe edges.
    logic [15:0] mem [0:1023];
    logic        mem_init = 1'b1;
    assign dq_i  = mem[sram_addr[9:0]];
    assign dq_i0 = pat0(addr0);

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= initpat(i);
        end else if (!ce_n && !we_n && dq_oe) begin
            if (!ub_n) mem[sram_addr[9:0]][15:8] <= dq_o[15:8];
            if (!lb_n) mem[sram_addr[9:0]][7:0] <= dq_o[7:0];
        end
    end

    // Reference model: a big-endian byte array.
    logic [7:0]  ref_b [0:2047];
    logic [31:0] prev_rd = 32'h0;

    int n_chk = 0;
    int n_fail = 0;

    function automatic int exp_lat(input logic [3:0] s);
        int n;
`ifdef WB_SRAM_SKIP_UNSEL_EN
        n = int'(|s[3:2]) + int'(|s[1:0]);
`else
        n = 2 + 0 * int'(s[0]);
`endif
        return 1 + n * (WS + 2);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d);
        int b = int'(a[10:0]);
        for (int k = 0; k < 4; k++)
            if (s[3-k]) ref_b[b+k] = d[31-8*k -: 8];
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int b = int'(a[10:0]);
        return {ref_b[b], ref_b[b+1], ref_b[b+2], ref_b[b+3]};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a,
                                               input logic [3:0] s);
        logic [31:0] w = model_word(a);
`ifdef WB_SRAM_SKIP_UNSEL_EN
        if (!(|s[3:2])) w[31:16] = prev_rd[31:16];
        if (!(|s[1:0])) w[15:0] = prev_rd[15:0];
`else
        w = w | (32'h0 & {28'h0, s});
`endif
        return w;
    endfunction

    // Per-access observations gathered by run().
    int          lat;
    int          ce_cnt [2];
    int          strb_cnt [2];
    logic        ub_seen [2];
    logic        lb_seen [2];
    logic [15:0] dq_seen [2];
    logic [17:0] addr_seen [2];
    int          ctl_bad;
    logic [31:0] rd_seen;
    logic        ack_again;

    task automatic run(input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
        int h;
        bit got = 0;
        for (int k = 0; k < 2; k++) begin
            ce_cnt[k] = 0; strb_cnt[k] = 0; ub_seen[k] = 1'bx;
            lb_seen[k] = 1'bx; dq_seen[k] = 'x; addr_seen[k] = 'x;
        end
        ctl_bad = 0;
        rd_seen = 'x;
        we = w; adr = a; sel = s; dat_w = d; cyc = 1; stb = 1;
        lat = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (!ce_n) begin
                h = int'(sram_addr[0]);
                ce_cnt[h]++;
                addr_seen[h] = sram_addr;
                if (!we_n || !oe_n) begin
                    strb_cnt[h]++;
                    ub_seen[h] = ub_n; lb_seen[h] = lb_n;
                    dq_seen[h] = dq_o;
                    if (w && !dq_oe) ctl_bad++;
                end
            end
            if ((w && !oe_n) || (!w && (!we_n || dq_oe))) ctl_bad++;
            if (ack) begin
                got = 1; lat = i + 1; rd_seen = dat_r;
            end
        end
        cyc = 0; stb = 0;
        @(posedge clk); #1;
        ack_again = ack;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #10;
        n_chk++;
        if ({ack, dat_r, sram_addr, dq_o, dq_oe} !== '0) begin
            n_fail++;
            $display("FAIL reset_zero: got ack=%b dat=%h addr=%h dq=%h oe=%b want all 0",
                     ack, dat_r, sram_addr, dq_o, dq_oe);
        end
        n_chk++;
        if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111) begin
            n_fail++;
            $display("FAIL reset_n_high: got %b want 11111",
                     {ce_n, oe_n, we_n, ub_n, lb_n});
        end
        n_chk++;
        if ({ack0, dq_oe0, ce_n0, we_n0, oe_n0} !== 5'b00111) begin
            n_fail++;
            $display("FAIL reset_dut0: got %b want 00111",
                     {ack0, dq_oe0, ce_n0, we_n0, oe_n0});
        end
        repeat (3) @(posedge clk);
        #1 mem_init = 1'b0;
        for (int h = 0; h < 1024; h++) begin
            ref_b[2*h]   = initpat(h)[15:8];
            ref_b[2*h+1] = initpat(h)[7:0];
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_write;
        run(1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        model_write(32'h100, 4'hF, 32'hDEADBEEF);
        n_chk++;
        if (lat !== 2 * (WS + 2) + 1) begin
            n_fail++;
            $display("FAIL ww_latency: got %0d want %0d", lat, 2 * (WS + 2) + 1);
        end
        n_chk++;
        if ({addr_seen[0], addr_seen[1]} !== {18'h80, 18'h81}) begin
            n_fail++;
            $display("FAIL ww_addr: got %h %h want 80 81", addr_seen[0], addr_seen[1]);
        end
        n_chk++;
        if ({dq_seen[0], dq_seen[1]} !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL ww_data: got %h %h want dead beef", dq_seen[0], dq_seen[1]);
        end
        n_chk++;
        if (strb_cnt[0] !== WS + 1 || strb_cnt[1] !== WS + 1 ||
            ce_cnt[0] !== WS + 2 || ce_cnt[1] !== WS + 2) begin
            n_fail++;
            $display("FAIL ww_phase_len: got strb %0d/%0d ce %0d/%0d want %0d %0d",
                     strb_cnt[0], strb_cnt[1], ce_cnt[0], ce_cnt[1], WS + 1, WS + 2);
        end
        n_chk++;
        if (ctl_bad !== 0 || ack_again !== 1'b0 || rd_seen !== prev_rd) begin
            n_fail++;
            $display("FAIL ww_ctl: got bad=%0d ack2=%b dat=%h want 0 0 %h",
                     ctl_bad, ack_again, rd_seen, prev_rd);
        end
    endtask

    task automatic test_word_read;
        run(1'b1, 32'h100, 4'hF, 32'h12345678);
        model_write(32'h100, 4'hF, 32'h12345678);
        run(1'b0, 32'h100, 4'hF, 32'h0);
        n_chk++;
        if (rd_seen !== 32'h12345678 || lat !== 2 * (WS + 2) + 1) begin
            n_fail++;
            $display("FAIL wr_data: got %h lat %0d want 12345678 lat %0d",
                     rd_seen, lat, 2 * (WS + 2) + 1);
        end
        n_chk++;
        if (dat_r !== 32'h12345678 || ctl_bad !== 0) begin
            n_fail++;
            $display("FAIL wr_hold: got %h bad=%0d want 12345678 0", dat_r, ctl_bad);
        end
        prev_rd = 32'h12345678;
    endtask

    task automatic test_byte_write;
        run(1'b1, 32'h200, 4'b0100, 32'h00AA0000);
        model_write(32'h200, 4'b0100, 32'h00AA0000);
        n_chk++;
        if ({ub_seen[0], lb_seen[0]} !== 2'b10 || dq_seen[0] !== 16'h00AA) begin
            n_fail++;
            $display("FAIL bw_h0: got ub=%b lb=%b dq=%h want 1 0 00aa",
                     ub_seen[0], lb_seen[0], dq_seen[0]);
        end
`ifdef WB_SRAM_SKIP_UNSEL_EN
        n_chk++;
        if (strb_cnt[1] !== 0 || ce_cnt[1] !== 0) begin
            n_fail++;
            $display("FAIL bw_h1: got strb=%0d ce=%0d want 0 0", strb_cnt[1], ce_cnt[1]);
        end
`else
        n_chk++;
        if (strb_cnt[1] !== WS + 1 || {ub_seen[1], lb_seen[1]} !== 2'b11) begin
            n_fail++;
            $display("FAIL bw_h1: got strb=%0d ub=%b lb=%b want %0d 1 1",
                     strb_cnt[1], ub_seen[1], lb_seen[1], WS + 1);
        end
`endif
        n_chk++;
        if (lat !== exp_lat(4'b0100)) begin
            n_fail++;
            $display("FAIL bw_latency: got %0d want %0d", lat, exp_lat(4'b0100));
        end
        run(1'b0, 32'h200, 4'hF, 32'h0);
        n_chk++;
        if (rd_seen !== model_read(32'h200, 4'hF)) begin
            n_fail++;
            $display("FAIL bw_readback: got %h want %h", rd_seen, model_read(32'h200, 4'hF));
        end
        prev_rd = model_read(32'h200, 4'hF);
    endtask

    task automatic test_random;
        logic        w;
        logic [3:0]  s;
        logic [31:0] a, d, e;
        for (int n = 0; n < 30; n++) begin
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom_range(0, 15));
            a = {21'h0, 9'($urandom_range(0, 511)), 2'b00};
            d = $urandom;
            run(w, a, s, d);
            if (w) begin
                model_write(a, s, d);
                e = prev_rd;
            end else begin
                e = model_read(a, s);
                prev_rd = e;
            end
            n_chk++;
            if (rd_seen !== e || lat !== exp_lat(s)) begin
                n_fail++;
                $display("FAIL rnd_%0d we=%b sel=%h adr=%h: got dat=%h lat=%0d want %h %0d",
                         n, w, s, a, rd_seen, lat, e, exp_lat(s));
            end
            n_chk++;
            if (ctl_bad !== 0 || ack_again !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_ctl_%0d: got bad=%0d ack2=%b want 0 0",
                         n, ctl_bad, ack_again);
            end
        end
    endtask

    task automatic test_abort;
        int   seen_h1 = 0;
        int   seen_ack = 0;
        bit   in_strb = 0;
        we = 1; adr = 32'h300; sel = 4'hF; dat_w = 32'hCAFEF00D;
        cyc = 1; stb = 1;
        for (int i = 0; i < 10 && !in_strb; i++) begin
            @(posedge clk); #1;
            if (!we_n) in_strb = 1;
        end
        cyc = 0; stb = 0;
        n_chk++;
        if (!in_strb) begin
            n_fail++;
            $display("FAIL abort_strobe: got no we_n pulse want one within 10 cycles");
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (!ce_n && sram_addr[0]) seen_h1++;
            if (ack) seen_ack++;
        end
        n_chk++;
        if (seen_h1 !== 0 || seen_ack !== 0) begin
            n_fail++;
            $display("FAIL abort_h1: got h1_cycles=%0d acks=%0d want 0 0", seen_h1, seen_ack);
        end
        n_chk++;
        if ({ce_n, oe_n, we_n, ub_n, lb_n, dq_oe} !== 6'b111110) begin
            n_fail++;
            $display("FAIL abort_idle: got %b want 111110",
                     {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe});
        end
        model_write(32'h300, 4'b1100, 32'hCAFEF00D);
        run(1'b0, 32'h300, 4'hF, 32'h0);
        n_chk++;
        if (rd_seen !== model_read(32'h300, 4'hF) || lat !== exp_lat(4'hF)) begin
            n_fail++;
            $display("FAIL abort_after: got %h lat %0d want %h %0d",
                     rd_seen, lat, model_read(32'h300, 4'hF), exp_lat(4'hF));
        end
        prev_rd = model_read(32'h300, 4'hF);
    endtask

    task automatic test_back_to_back;
        int l;
        logic [31:0] a;
        logic [17:0] hw;
        for (int n = 0; n < 4; n++) begin
            a = {21'h0, 9'($urandom_range(0, 511)), 2'b00};
            hw = {a[17:2], 1'b0};
            adr0 = a; cyc0 = 1; stb0 = 1;
            l = -1;
            for (int i = 0; i < 20 && l < 0; i++) begin
                @(posedge clk); #1;
                if (ack0) l = i + 1;
            end
            n_chk++;
            if (l !== 5 || dat_r0 !== {pat0(hw), pat0(hw + 18'd1)}) begin
                n_fail++;
                $display("FAIL b2b_%0d: got lat=%0d dat=%h want 5 %h",
                         n, l, dat_r0, {pat0(hw), pat0(hw + 18'd1)});
            end
            cyc0 = 0; stb0 = 0;
            @(posedge clk); #1;
            n_chk++;
            if (ack0 !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap_%0d: got ack=%b want 0", n, ack0);
            end
        end
    endtask

    task automatic test_reset_midwrite;
        bit in_strb = 0;
        we = 1; adr = 32'h400; sel = 4'hF; dat_w = 32'h55AA33CC;
        cyc = 1; stb = 1;
        for (int i = 0; i < 10 && !in_strb; i++) begin
            @(posedge clk); #1;
            if (!we_n) in_strb = 1;
        end
        n_chk++;
        if (!in_strb || dq_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got strobe=%0d dq_oe=%b want 1 1", in_strb, dq_oe);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({we_n, ce_n, oe_n, ub_n, lb_n, dq_oe, ack} !== 7'b1111100) begin
            n_fail++;
            $display("FAIL rst_mid_async: got %b want 1111100",
                     {we_n, ce_n, oe_n, ub_n, lb_n, dq_oe, ack});
        end
        cyc = 0; stb = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_word_read();
        test_byte_write();
        test_random();
        test_abort();
        test_back_to_back();
        test_reset_midwrite();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
